// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and payload width.
// Optional build macro: TX_CTRL_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int DATA_BITS = 8;

`ifdef TX_CTRL_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } tx_state_t;
`endif

endpackage

// File: rtl/flex_counter.sv
// Free-running cycle counter with synchronous clear and programmable
// rollover point. rollover_flag is high in the enabled cycle whose count
// equals rollover_val; the count then returns to zero on the next edge.
module flex_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count_q;

  assign rollover_flag = count_enable && (count_q == rollover_val);

  // Count register: clear wins, otherwise advance and wrap at rollover_val.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_enable) begin
      count_q <= rollover_flag ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/tx_ctrl.sv
// Serial byte transmitter: start bit, 8 data bits LSB first, stop bit,
// each held BIT_PERIOD clocks. Valid/ready handshake accepted only in IDLE.
// Optional build macro: TX_CTRL_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit.
module tx_ctrl
  import uart_pkg::*;
#(
  parameter int BIT_PERIOD = 10,
  parameter int DATA_BITS  = uart_pkg::DATA_BITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_done
);

  localparam int             CNT_W    = 10;
  localparam logic [CNT_W-1:0] ROLL   = CNT_W'(BIT_PERIOD - 1);
  localparam logic [2:0]     LAST_IDX = 3'(DATA_BITS - 1);

  tx_state_t              state_q, state_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [2:0]             idx_q, idx_d;
  logic                   out_d;
  logic                   done_d;
  logic                   bit_done;
  logic                   cnt_clear;
  logic                   cnt_en;
`ifdef TX_CTRL_PARITY_EN
  logic                   par_q;
`endif

  // Bit timer restarts on every state change and is held at zero in IDLE.
  assign cnt_en    = (state_q != IDLE);
  assign cnt_clear = (state_d != state_q) || (state_q == IDLE);
  assign tx_ready  = (state_q == IDLE);

  flex_counter #(
    .WIDTH(CNT_W)
  ) u_bit_cnt (
    .clk          (clk),
    .rst          (rst),
    .clear        (cnt_clear),
    .count_enable (cnt_en),
    .rollover_val (ROLL),
    .rollover_flag(bit_done)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, next shift/index and registered line value.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    out_d   = 1'b1;
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d = START;
          shreg_d = tx_data;
          idx_d   = 3'd0;
        end
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shreg_d = shreg_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == LAST_IDX) begin
`ifdef TX_CTRL_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef TX_CTRL_PARITY_EN
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Line level follows the state being entered so tx_out can be a flop.
    case (state_d)
      START:   out_d = 1'b0;
      DATA:    out_d = shreg_d[0];
`ifdef TX_CTRL_PARITY_EN
      PARITY:  out_d = par_q;
`endif
      default: out_d = 1'b1;
    endcase
  end

  // Datapath and output registers; reset abandons any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      idx_q   <= 3'd0;
      tx_out  <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      tx_out  <= out_d;
      tx_done <= done_d;
    end
  end

`ifdef TX_CTRL_PARITY_EN
  // Even-parity bit captured from the byte at the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (state_q == IDLE && tx_valid) begin
      par_q <= ^tx_data;
    end
  end
`endif

endmodule

// File: tb/tb_tx_ctrl.sv
// Bench for tx_ctrl: main instance at BIT_PERIOD=4, second at BIT_PERIOD=2.
// Expected line levels are built per cycle into a queue at each handshake
// and popped as the transmitter runs.
module tb_tx_ctrl;

`ifdef TX_CTRL_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       va, vb;
  logic [7:0] da, db;
  logic       ra, rb, oa, ob, dna, dnb;

  int  compared   = 0;
  int  mismatched = 0;
  int  done_cnt_a = 0;
  bit  cur_sel    = 1'b0;
  logic exp_q[$];

  logic o_obs, r_obs, d_obs;
  assign o_obs = cur_sel ? ob  : oa;
  assign r_obs = cur_sel ? rb  : ra;
  assign d_obs = cur_sel ? dnb : dna;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  tx_ctrl #(.BIT_PERIOD(4)) dut_a (
    .clk(clk), .rst(rst), .tx_valid(va), .tx_data(da),
    .tx_ready(ra), .tx_out(oa), .tx_done(dna)
  );

  tx_ctrl #(.BIT_PERIOD(2)) dut_b (
    .clk(clk), .rst(rst), .tx_valid(vb), .tx_data(db),
    .tx_ready(rb), .tx_out(ob), .tx_done(dnb)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dna === 1'b1) done_cnt_a <= done_cnt_a + 1;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Entered just after a negedge with the selected DUT idle. Returns at the
  // negedge of the tx_done cycle with tx_valid still as left by the caller.
  task automatic frame(input bit sel, input logic [7:0] d, input logic ep,
                       input bit hold, input logic [7:0] busy);
    int bp;
    logic e;
    bp = sel ? 2 : 4;
    cur_sel = sel;
    exp_q.delete();
    for (int k = 0; k < bp; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < bp; k++) exp_q.push_back(d[i]);
`ifdef TX_CTRL_PARITY_EN
    for (int k = 0; k < bp; k++) exp_q.push_back(ep);
`else
    if (ep === 1'bx) exp_q.push_back(1'b1);
`endif
    for (int k = 0; k < bp; k++) exp_q.push_back(1'b1);
    cmp($sformatf("ready_before_%02h", d), {31'd0, r_obs}, 32'd1);
    if (sel) begin vb = 1'b1; db = d; end else begin va = 1'b1; da = d; end
    @(posedge clk);
    @(negedge clk);
    if (sel) vb = 1'b0;
    else if (hold) da = busy;
    else va = 1'b0;
    for (int j = 0; j < NB * bp; j++) begin
      if (exp_q.size() == 0) begin
        cmp("queue_underrun", 32'd0, 32'd1);
        break;
      end
      e = exp_q.pop_front();
      cmp($sformatf("line_%02h_c%0d{out,done,ready}", d, j),
          {29'd0, o_obs, d_obs, r_obs}, {29'd0, e, 2'b00});
      @(negedge clk);
    end
    cmp($sformatf("done_%02h{out,done,ready}", d),
        {29'd0, o_obs, d_obs, r_obs}, 32'd7);
  endtask

  vec_t tbl[4];
  int   snap;

  initial begin
    tbl[0] = '{8'hA5, 1'b0};
    tbl[1] = '{8'h07, 1'b1};
    tbl[2] = '{8'h00, 1'b0};
    tbl[3] = '{8'h3C, 1'b0};

    rst = 1'b1; va = 1'b0; vb = 1'b0; da = 8'h00; db = 8'h00;
    repeat (3) @(negedge clk);
    cmp("reset_a{out,done,ready}", {29'd0, oa, dna, ra}, 32'd5);
    cmp("reset_b{out,done,ready}", {29'd0, ob, dnb, rb}, 32'd5);

    // Handshake attempted while reset is held must be ignored.
    va = 1'b1; da = 8'h00;
    repeat (2) @(negedge clk);
    va = 1'b0;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      cmp("no_hs_in_reset{out,ready}", {30'd0, oa, ra}, 32'd3);
    end

    // Table of single frames with an idle gap between them.
    foreach (tbl[i]) begin
      frame(1'b0, tbl[i].data, tbl[i].par, 1'b0, 8'h00);
      @(negedge clk);
      cmp("done_one_cycle{out,done,ready}", {29'd0, oa, dna, ra}, 32'd5);
    end

    // Busy ignore: valid held, data changed mid-frame, next frame follows.
    snap = done_cnt_a;
    frame(1'b0, 8'hA5, 1'b0, 1'b1, 8'hFF);
    frame(1'b0, 8'hFF, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    cmp("busy_done_pulses", done_cnt_a - snap, 32'd2);

    // Back-to-back 0x00 then 0xFF.
    snap = done_cnt_a;
    frame(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    frame(1'b0, 8'hFF, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    cmp("b2b_done_pulses", done_cnt_a - snap, 32'd2);
    cmp("b2b_idle_after{out,done,ready}", {29'd0, oa, dna, ra}, 32'd5);

    // Minimum bit period on the second instance.
    frame(1'b1, 8'h80, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    cmp("bp2_idle_after{out,done,ready}", {29'd0, ob, dnb, rb}, 32'd5);
    cur_sel = 1'b0;

    // Asynchronous reset in the middle of the data bits.
    va = 1'b1; da = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    va = 1'b0;
    repeat (9) @(negedge clk);
    cmp("mid_data_low_before_rst", {31'd0, oa}, 32'd0);
    #2 rst = 1'b1;
    #1;
    cmp("async_rst{out,done,ready}", {29'd0, oa, dna, ra}, 32'd5);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      cmp("idle_after_rst{out,done,ready}", {29'd0, oa, dna, ra}, 32'd5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
